// File: rtl/nrda_pkg.sv
// Shared types and constants for the nrda_div sequencing stage.
package nrda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand the helpers support; callers cast down to their own WIDTH.
  localparam int MAX_WIDTH = 128;

  localparam logic [MAX_WIDTH-1:0] DZ_Q  = '1;
  localparam logic [MAX_WIDTH-1:0] OVF_R = '0;

  function automatic logic [MAX_WIDTH-1:0] min_val(input int width);
    min_val = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

endpackage

// File: rtl/nrda_special_det.sv
// Detects divide-by-zero and MIN/-1 overflow and supplies their fixed results.
module nrda_special_det
  import nrda_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             is_dz,
  output logic             is_ovf,
  output logic [WIDTH-1:0] sp_q,
  output logic [WIDTH-1:0] sp_r
);

  localparam logic [WIDTH-1:0] MIN = WIDTH'(min_val(WIDTH));

  always_comb begin
    is_dz  = (y == '0);
    // Divide-by-zero wins; the two cases are disjoint anyway.
    is_ovf = !is_dz && (x == MIN) && (y == '1);
    sp_q   = is_dz ? WIDTH'(DZ_Q) : MIN;
    sp_r   = is_dz ? x : WIDTH'(OVF_R);
  end

endmodule

// File: rtl/nrda_div_seq.sv
// Multicycle sequencer around the combinational nrda_div divider.
// Optional out_dz/out_ovf flag ports are enabled by defining NRDA_DIV_FLAGS_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// valid never waits on ready, and payload is held while valid && !ready.
module nrda_div_seq
  import nrda_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MC_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r
`ifdef NRDA_DIV_FLAGS_EN
  ,
  output logic             out_dz,
  output logic             out_ovf
`endif
);

  state_t           state;
  state_t           state_next;
  logic [7:0]       cnt;
  logic             accept;
  logic             special;
  logic             is_dz;
  logic             is_ovf;
  logic [WIDTH-1:0] sp_q;
  logic [WIDTH-1:0] sp_r;

  nrda_special_det #(.WIDTH(WIDTH)) u_det (
    .x      (in_x),
    .y      (in_y),
    .is_dz  (is_dz),
    .is_ovf (is_ovf),
    .sp_q   (sp_q),
    .sp_r   (sp_r)
  );

  assign special = is_dz | is_ovf;
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid) state_next = special ? DONE : WAIT;
      WAIT: if (cnt == 8'd0) state_next = DONE;
      // Retiring a result and taking the next request share one edge.
      DONE: if (out_ready) state_next = in_valid ? (special ? DONE : WAIT) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 8'd0;
      div_x <= '0;
      div_y <= '0;
      out_q <= '0;
      out_r <= '0;
`ifdef NRDA_DIV_FLAGS_EN
      out_dz  <= 1'b0;
      out_ovf <= 1'b0;
`endif
    end else if (accept) begin
      if (special) begin
        out_q <= sp_q;
        out_r <= sp_r;
`ifdef NRDA_DIV_FLAGS_EN
        out_dz  <= is_dz;
        out_ovf <= is_ovf;
`endif
      end else begin
        // div_x/div_y only move here, so the divider sees stable inputs all through WAIT.
        div_x <= in_x;
        div_y <= in_y;
        cnt   <= 8'(MC_CYCLES - 1);
      end
    end else if (state == WAIT) begin
      if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end else begin
        out_q <= div_q;
        out_r <= div_r;
`ifdef NRDA_DIV_FLAGS_EN
        out_dz  <= 1'b0;
        out_ovf <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_nrda_div_seq.sv
// Directed bench for nrda_div_seq with a behavioural signed divider behind it.
module tb_nrda_div_seq;

  localparam int W = 32;
  localparam int MC = 4;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    logic         dz;
    logic         ovf;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic [W-1:0] div_x;
  logic [W-1:0] div_y;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
  logic [W-1:0] out_r;
`ifdef NRDA_DIV_FLAGS_EN
  logic         out_dz;
  logic         out_ovf;
`endif

  int n_tests;
  int n_fail;
  logic [W-1:0] last_x;
  logic [W-1:0] last_y;

  nrda_div_seq #(.WIDTH(W), .MC_CYCLES(MC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .div_x     (div_x),
    .div_y     (div_y),
    .div_q     (div_q),
    .div_r     (div_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r)
`ifdef NRDA_DIV_FLAGS_EN
    ,
    .out_dz    (out_dz),
    .out_ovf   (out_ovf)
`endif
  );

  // Behavioural stand-in for nrda_div: truncating division, remainder follows dividend.
  always_comb begin
    if (div_y == '0 || (div_x == MIN && div_y == '1)) begin
      div_q = '0;
      div_r = '0;
    end else begin
      div_q = $signed(div_x) / $signed(div_y);
      div_r = $signed(div_x) % $signed(div_y);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits for out_valid, counting edges from the accept edge (which counts as 1).
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_flags(input string name, input logic dz, input logic ovf);
`ifdef NRDA_DIV_FLAGS_EN
    check({name, "_dz"}, W'(out_dz), W'(dz));
    check({name, "_ovf"}, W'(out_ovf), W'(ovf));
`else
    if (dz && ovf) $display("note: %s has both flags set in its table entry", name);
`endif
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int guard;
    int lat;
    @(negedge clk);
    in_x = v.x;
    in_y = v.y;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_in_ready"}, W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_x = $urandom;
    in_y = $urandom;
    wait_result(lat);
    check({name, "_lat"}, W'(lat), W'(v.lat));
    check({name, "_q"}, out_q, v.q);
    check({name, "_r"}, out_r, v.r);
    check_flags(name, v.dz, v.ovf);
    if (v.lat != 1) begin
      last_x = v.x;
      last_y = v.y;
    end
    check({name, "_div_x"}, div_x, last_x);
    check({name, "_div_y"}, div_y, last_y);
  endtask

  initial begin
    vec_t vecs[11];
    logic [W-1:0] bx[3];
    logic [W-1:0] by[3];
    logic [W-1:0] bq[3];
    logic [W-1:0] br[3];
    int lat;

    vecs[0]  = '{x: 32'd1436,        y: 32'd135,     q: 32'd10,         r: 32'd86,       lat: 5, dz: 1'b0, ovf: 1'b0};
    vecs[1]  = '{x: 32'd100,         y: 32'd7,       q: 32'd14,         r: 32'd2,        lat: 5, dz: 1'b0, ovf: 1'b0};
    vecs[2]  = '{x: -32'sd7,         y: 32'd2,       q: -32'sd3,        r: -32'sd1,      lat: 5, dz: 1'b0, ovf: 1'b0};
    vecs[3]  = '{x: 32'd7,           y: -32'sd2,     q: -32'sd3,        r: 32'd1,        lat: 5, dz: 1'b0, ovf: 1'b0};
    vecs[4]  = '{x: 32'd77,          y: 32'd0,       q: 32'hFFFF_FFFF,  r: 32'd77,       lat: 1, dz: 1'b1, ovf: 1'b0};
    vecs[5]  = '{x: MIN,             y: 32'hFFFF_FFFF, q: MIN,          r: 32'd0,        lat: 1, dz: 1'b0, ovf: 1'b1};
    vecs[6]  = '{x: MIN,             y: 32'd1,       q: MIN,            r: 32'd0,        lat: 5, dz: 1'b0, ovf: 1'b0};
    vecs[7]  = '{x: 32'd0,           y: 32'd5,       q: 32'd0,          r: 32'd0,        lat: 5, dz: 1'b0, ovf: 1'b0};
    vecs[8]  = '{x: 32'hFFFF_FFFF,   y: 32'd0,       q: 32'hFFFF_FFFF,  r: 32'hFFFF_FFFF, lat: 1, dz: 1'b1, ovf: 1'b0};
    vecs[9]  = '{x: MIN,             y: 32'd0,       q: 32'hFFFF_FFFF,  r: MIN,          lat: 1, dz: 1'b1, ovf: 1'b0};
    vecs[10] = '{x: MIN,             y: 32'd2,       q: 32'hC000_0000,  r: 32'd0,        lat: 5, dz: 1'b0, ovf: 1'b0};

    n_tests = 0;
    n_fail = 0;
    last_x = '0;
    last_y = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    in_y = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", W'(in_ready), W'(1));
    check("post_rst_out_q", out_q, '0);
    check("post_rst_out_r", out_r, '0);
    check("post_rst_div_x", div_x, '0);
    check_flags("post_rst", 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back: each result retires on the edge that accepts the next request.
    bx = '{32'hFFFF_FA64, 32'd1436, 32'hFFFF_FA64};
    by = '{32'd135, 32'hFFFF_FF79, 32'hFFFF_FF79};
    bq = '{32'hFFFF_FFF6, 32'hFFFF_FFF6, 32'd10};
    br = '{32'hFFFF_FFAA, 32'd86, 32'hFFFF_FFAA};
    @(negedge clk);
    in_x = bx[0];
    in_y = by[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) begin
        in_x = bx[k+1];
        in_y = by[k+1];
      end else begin
        in_valid = 1'b0;
      end
      wait_result(lat);
      check($sformatf("b2b%0d_lat", k), W'(lat), W'(5));
      check($sformatf("b2b%0d_q", k), out_q, bq[k]);
      check($sformatf("b2b%0d_r", k), out_r, br[k]);
      if (k < 2) check($sformatf("b2b%0d_in_ready", k), W'(in_ready), W'(1));
      @(posedge clk);
    end

    // Output stall with a pending request.
    @(negedge clk);
    in_x = 32'd100;
    in_y = 32'd7;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_x = 32'd9;
    in_y = 32'd3;
    wait_result(lat);
    check("stall_lat", W'(lat), W'(5));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_out_valid", W'(out_valid), W'(1));
      check("stall_out_q", out_q, 32'd14);
      check("stall_out_r", out_r, 32'd2);
      check("stall_in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    check("pending_lat", W'(lat), W'(5));
    check("pending_q", out_q, 32'd3);
    check("pending_r", out_r, 32'd0);

    // Reset during the second WAIT cycle.
    @(negedge clk);
    in_x = 32'd1436;
    in_y = 32'd135;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready_low", W'(in_ready), W'(0));
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_out_q", out_q, '0);
    check("midrst_out_r", out_r, '0);
    check("midrst_div_x", div_x, '0);
    check("midrst_div_y", div_y, '0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready_high", W'(in_ready), W'(1));
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_result", W'(out_valid), W'(0));
    end
    last_x = '0;
    last_y = '0;
    run_vec("after_rst", vecs[1]);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nrda_div_seq.md
Name: nrda_div_seq

Overview:
- Sequencing stage placed directly upstream and downstream of the combinational signed non-restoring divider `nrda_div`.
- Accepts signed divide requests over a valid/ready handshake and holds the operands stable on the divider inputs for a multicycle window of MC_CYCLES clocks.
- Captures q/r into an output register and presents them over a valid/ready handshake.
- Resolves divide-by-zero and overflow without waiting on the divider.

Parameters:
- WIDTH, 32, operand/result width (two's complement).
- MC_CYCLES, 4, clocks allowed for the divider combinational path; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at a clk edge.
- in_x  in  WIDTH  signed dividend.
- in_y  in  WIDTH  signed divisor.
- div_x  out  WIDTH  registered dividend to nrda_div.x.
- div_y  out  WIDTH  registered divisor to nrda_div.y.
- div_q  in  WIDTH  quotient from nrda_div.q.
- div_r  in  WIDTH  remainder from nrda_div.r.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_q  out  WIDTH  registered quotient.
- out_r  out  WIDTH  registered remainder.

Behaviour:
- Reset (synchronous, active-high, any state, mid-operation included):
  - state=IDLE, cnt=0, div_x=div_y=0, out_q=out_r=0, out_valid=0.
  - Any in-flight request is discarded.
  - in_ready=0 during the reset cycle and 1 from the first cycle after it.
- States: IDLE, WAIT, DONE. cnt is 8 bits.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational, no dependence on in_valid.
- Accept in IDLE, or in DONE with out_ready:
  - Normal request: div_x<=in_x, div_y<=in_y, cnt<=MC_CYCLES-1, state<=WAIT.
  - Special case (in_y==0, or in_x==MIN && in_y==-1): out_q/out_r loaded directly, state<=DONE, div_x/div_y unchanged.
- DONE && out_ready && !in_valid: state<=IDLE, out_valid<=0.
- WAIT:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: out_q<=div_q, out_r<=div_r, state<=DONE.
- out_valid==1 exactly in DONE.
- Latency:
  - Normal request: out_valid rises MC_CYCLES+1 edges after the accept edge.
  - Special case: out_valid rises on the edge following the accept.
- Back-to-back: in DONE with out_ready && in_valid, the current result retires and the new request is accepted on the same edge. No bubble is required on the input side.
- While out_valid && !out_ready: out_q, out_r and out_valid are held stable, and in_ready=0.
- div_x and div_y change only on accept edges, so the divider inputs are stable for the whole WAIT window.
- Arithmetic: truncating division; remainder takes the sign of the dividend. nrda_div output is used unmodified for normal cases.
- Special-case results:
  - y==0: q = all ones (-1), r = x.
  - x==MIN (1 followed by WIDTH-1 zeros) && y==-1: q = MIN, r = 0.
  - Both conditions cannot hold at once; the y==0 check has priority in the logic.
- in_x/in_y are sampled only on the accept edge; changes at other times are ignored.

Optional Feature:
- Macro NRDA_DIV_FLAGS_EN.
- When defined, two extra output ports are added:
  - out_dz (1 bit): divide-by-zero flag.
  - out_ovf (1 bit): MIN/-1 overflow flag.
- Both flags are registered alongside out_q/out_r, cleared on reset, cleared on every normal capture, and held with out_valid.
- When undefined, the ports do not exist and special-case results are produced identically with no flag indication.

Decomposition:
- Package nrda_pkg holds:
  - state enum {IDLE, WAIT, DONE}.
  - Function returning MIN for a given WIDTH.
  - Special-result constants: DZ_Q = all ones, OVF_R = 0.
- One sub-module, nrda_special_det: combinational; inputs x, y; outputs is_dz, is_ovf, sp_q, sp_r.
- The FSM, counter and registers stay in nrda_div_seq.

Test Plan (WIDTH=32, MC_CYCLES=4, nrda_div instantiated behind the block):
- 1436/135, out_ready=1 -> out_valid 5 edges after accept; q=10, r=86.
- Sequence -1436/135, 1436/-135, -1436/-135 issued back-to-back, in_valid held high -> q=-10 r=-86; q=-10 r=86; q=10 r=-86. Each result follows its accept after 5 edges; each next request is accepted on the retiring edge.
- 77/0 -> out_valid on the edge after accept, q=0xFFFFFFFF, r=77. With NRDA_DIV_FLAGS_EN: out_dz=1, out_ovf=0.
- 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0 one edge after accept. With flags: out_ovf=1.
- out_ready held 0 for 10 cycles after a result -> out_q/out_r/out_valid stable, in_ready=0, pending in_valid not accepted. Raising out_ready retires the result and accepts the pending request on the same edge.
- rst asserted on the 2nd cycle of WAIT -> next cycle out_valid=0, in_ready=1, outputs 0. A fresh 100/7 then yields q=14, r=2.
